memory_issue_unit: RTL and testbench
====================================

# memory_issue_unit

Memory-1 stage logic of the 7-stage pipeline: consumes the execute→memory1 register outputs, issues load/store requests to the data memory over a valid/ready handshake, and aligns store data into byte lanes. It tracks up to DEPTH outstanding loads and returns sign/zero-extended load data, registered, to the memory2 stage. It raises a stall to the hazard unit while a memory op in memory1 cannot issue.

## Interface
- DATA_WIDTH, 32, datapath width (fixed at 32 for RV32 byte-lane logic)
- ADDRESS_BITS, 20, word-address width of the data memory
- DEPTH, 2, outstanding-load tracker depth (power of two, ≥2)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ALU_result_memory1  in  DATA_WIDTH  byte address
- store_data_memory1  in  DATA_WIDTH  unaligned store data (low bits valid)
- rd_memory1  in  5  destination register
- opcode_memory1  in  7  opcode
- memRead_memory1 / memWrite_memory1 / regWrite_memory1  in  1 each  control
- instruction_memory1  in  DATA_WIDTH  funct3 = bits [14:12]
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = store, 0 = load
- mem_req_address  out  ADDRESS_BITS  ALU_result_memory1[ADDRESS_BITS+1:2]
- mem_req_data  out  DATA_WIDTH  lane-aligned store data
- mem_req_byte_en  out  DATA_WIDTH/8  byte enables (all ones for loads)
- mem_rsp_valid  in  1  load response valid (loads only; stores get none)
- mem_rsp_data  in  DATA_WIDTH  raw word
- stall_memory1  out  1  freeze memory1 and upstream
- load_valid_memory2  out  1  load result valid
- load_data_memory2  out  DATA_WIDTH  extended load result
- load_rd_memory2  out  5  its destination
- protocol_error  out  1  sticky: response received with tracker empty

## Operation
- mem_op: load = memRead_memory1 & opcode_memory1==7'b0000011; store = memWrite_memory1 & opcode_memory1==7'b0100011. All other combinations (including memRead=1, opcode=0) issue nothing.
- mem_req_valid = store | (load & !full); full = registered count==DEPTH (a same-cycle pop does not free a slot for that cycle's push).
- stall_memory1 = mem_op & !(mem_req_valid & mem_req_ready). Acceptance and pipeline advance coincide, so each instruction issues exactly once; payload is stable while stalled because upstream is frozen.
- Store lanes, off = addr[1:0]: SB (funct3 000) data = {4{byte}}, byte_en = 1<<off; SH (001) data = {2{half}}, byte_en = 4'b0011<<(addr[1]*2), addr[0] ignored; SW (010) data as-is, byte_en 4'b1111, addr[1:0] ignored.
- Load accept pushes {rd, funct3, addr[1:0]} into a DEPTH-entry circular FIFO (wrap-around pointers, count 0..DEPTH).
- mem_rsp_valid with count>0 pops head: LB/LBU select byte at off*8, LH/LHU half at addr[1]*16, LW whole word; LB/LH sign-extend, LBU/LHU zero-extend; unlisted funct3 → treated as LW.
- mem_rsp_valid with count==0: ignored, protocol_error set until reset.
- Push and pop in same cycle: both occur, count unchanged.
- Responses return in request order; no reordering.

## Timing
- Request outputs and stall_memory1 are combinational from memory1 inputs, mem_req_ready and count: zero added latency.
- load_valid/data/rd_memory2 registered: asserted the cycle after mem_rsp_valid, for exactly one cycle per response.
- Throughput: one request per cycle; one response per cycle.
- Reset values: load_valid_memory2 0, load_data_memory2 0, load_rd_memory2 0, protocol_error 0, FIFO empty (pointers/count 0). Reset mid-operation discards all outstanding entries; the memory is reset in the same cycle by system convention.

## Test plan
- SB x5=0x000000AB to addr 0x1003, ready=1 → same cycle mem_req_write 1, address 0x400, data 0xABABABAB, byte_en 4'b1000, stall 0.
- LH rd=7 at 0x2002, rsp word 0x8001_1234 → next cycle load_valid 1, rd 7, data 0xFFFF8001; same with LHU → 0x00008001.
- Load with ready=0 for 3 cycles → stall_memory1 high 3 cycles, valid held with stable address, single push on 4th cycle.
- DEPTH=2: two loads accepted, no responses, third load → mem_req_valid 0, stall 1; response arrives → slot frees next cycle, third load issues then.
- Simultaneous push and pop at count 1 → count stays 1; responses return data for rd in issue order.
- Response with empty tracker → no load_valid, protocol_error 1 until reset; after reset memRead=1 with opcode 0 → no request.

Source files
------------

// File: rtl/memory_issue_unit.sv
// Memory-1 stage: issues loads/stores to data memory, lane-aligns store data,
// tracks outstanding loads in order and returns extended load data to memory2.
module memory_issue_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   ALU_result_memory1,
    input  logic [DATA_WIDTH-1:0]   store_data_memory1,
    input  logic [4:0]              rd_memory1,
    input  logic [6:0]              opcode_memory1,
    input  logic                    memRead_memory1,
    input  logic                    memWrite_memory1,
    input  logic                    regWrite_memory1,
    input  logic [DATA_WIDTH-1:0]   instruction_memory1,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_address,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [DATA_WIDTH/8-1:0] mem_req_byte_en,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic                    stall_memory1,
    output logic                    load_valid_memory2,
    output logic [DATA_WIDTH-1:0]   load_data_memory2,
    output logic [4:0]              load_rd_memory2,
    output logic                    protocol_error
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 10;

    // Select and extend the addressed byte/half of a returned word.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{byte_v[7]}}, byte_v};
            3'b100:  extend_load = {24'h000000, byte_v};
            3'b001:  extend_load = {{16{half_v[15]}}, half_v};
            3'b101:  extend_load = {16'h0000, half_v};
            default: extend_load = word;
        endcase
    endfunction

    logic [2:0]         funct3_s;
    logic [1:0]         offset_s;
    logic               is_load_s;
    logic               is_store_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               empty_rsp_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic [DATA_WIDTH-1:0]   lane_data_s;
    logic [DATA_WIDTH/8-1:0] lane_be_s;

    logic [ENTRY_W-1:0]    fifo_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic                  load_valid_r;
    logic [DATA_WIDTH-1:0] load_data_r;
    logic [4:0]            load_rd_r;
    logic                  protocol_error_r;

    logic unused_inputs_s;
    assign unused_inputs_s = ^{regWrite_memory1, instruction_memory1, ALU_result_memory1};

    assign funct3_s     = instruction_memory1[14:12];
    assign offset_s     = ALU_result_memory1[1:0];
    assign is_load_s    = memRead_memory1  && (opcode_memory1 == 7'b0000011);
    assign is_store_s   = memWrite_memory1 && (opcode_memory1 == 7'b0100011);
    // Full uses the registered count: a pop this cycle cannot make room for a push.
    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign push_s       = is_load_s && !full_s && mem_req_ready;
    assign pop_s        = mem_rsp_valid && (count_r != {CNT_W{1'b0}});
    assign empty_rsp_s  = mem_rsp_valid && (count_r == {CNT_W{1'b0}});
    assign head_entry_s = fifo_r[head_r];

    assign mem_req_valid   = is_store_s || (is_load_s && !full_s);
    assign mem_req_write   = is_store_s;
    assign mem_req_address = ALU_result_memory1[ADDRESS_BITS+1:2];
    assign mem_req_data    = lane_data_s;
    assign mem_req_byte_en = is_store_s ? lane_be_s : {(DATA_WIDTH/8){1'b1}};
    assign stall_memory1   = (is_load_s || is_store_s) && !(mem_req_valid && mem_req_ready);

    // Replicate store data across lanes and build the matching byte enables.
    always_comb begin
        lane_data_s = store_data_memory1;
        lane_be_s   = 4'b1111;
        case (funct3_s)
            3'b000: begin
                lane_data_s = {4{store_data_memory1[7:0]}};
                lane_be_s   = 4'b0001 << offset_s;
            end
            3'b001: begin
                lane_data_s = {2{store_data_memory1[15:0]}};
                if (offset_s[1]) begin
                    lane_be_s = 4'b1100;
                end else begin
                    lane_be_s = 4'b0011;
                end
            end
            3'b010: begin
                lane_data_s = store_data_memory1;
                lane_be_s   = 4'b1111;
            end
            default: begin
                lane_data_s = store_data_memory1;
                lane_be_s   = 4'b1111;
            end
        endcase
    end

    // Tracker storage: entries are only meaningful between push and pop.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_r[tail_r] <= {rd_memory1, funct3_s, offset_s};
        end
    end

    // Tracker pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= (tail_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= (head_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : head_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Registered load return to memory2 and sticky protocol error.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_valid_r     <= 1'b0;
            load_data_r      <= {DATA_WIDTH{1'b0}};
            load_rd_r        <= 5'd0;
            protocol_error_r <= 1'b0;
        end else begin
            load_valid_r <= pop_s;
            if (pop_s) begin
                load_data_r <= extend_load(mem_rsp_data, head_entry_s[4:2], head_entry_s[1:0]);
                load_rd_r   <= head_entry_s[9:5];
            end
            if (empty_rsp_s) begin
                protocol_error_r <= 1'b1;
            end
        end
    end

    assign load_valid_memory2 = load_valid_r;
    assign load_data_memory2  = load_data_r;
    assign load_rd_memory2    = load_rd_r;
    assign protocol_error     = protocol_error_r;

endmodule

// File: tb/tb_memory_issue_unit.sv
// Directed self-checking bench for memory_issue_unit with hand-computed expectations.
module tb_memory_issue_unit;

    logic        clock;
    logic        reset;
    logic [31:0] ALU_result_memory1;
    logic [31:0] store_data_memory1;
    logic [4:0]  rd_memory1;
    logic [6:0]  opcode_memory1;
    logic        memRead_memory1;
    logic        memWrite_memory1;
    logic        regWrite_memory1;
    logic [31:0] instruction_memory1;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [19:0] mem_req_address;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_byte_en;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        stall_memory1;
    logic        load_valid_memory2;
    logic [31:0] load_data_memory2;
    logic [4:0]  load_rd_memory2;
    logic        protocol_error;

    int checks_total;
    int checks_passed;

    memory_issue_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .DEPTH(2)) dut (
        .clock               (clock),
        .reset               (reset),
        .ALU_result_memory1  (ALU_result_memory1),
        .store_data_memory1  (store_data_memory1),
        .rd_memory1          (rd_memory1),
        .opcode_memory1      (opcode_memory1),
        .memRead_memory1     (memRead_memory1),
        .memWrite_memory1    (memWrite_memory1),
        .regWrite_memory1    (regWrite_memory1),
        .instruction_memory1 (instruction_memory1),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_write       (mem_req_write),
        .mem_req_address     (mem_req_address),
        .mem_req_data        (mem_req_data),
        .mem_req_byte_en     (mem_req_byte_en),
        .mem_rsp_valid       (mem_rsp_valid),
        .mem_rsp_data        (mem_rsp_data),
        .stall_memory1       (stall_memory1),
        .load_valid_memory2  (load_valid_memory2),
        .load_data_memory2   (load_data_memory2),
        .load_rd_memory2     (load_rd_memory2),
        .protocol_error      (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        memRead_memory1     = 1'b0;
        memWrite_memory1    = 1'b0;
        regWrite_memory1    = 1'b0;
        opcode_memory1      = 7'b0000000;
        ALU_result_memory1  = 32'h0;
        store_data_memory1  = 32'h0;
        rd_memory1          = 5'd0;
        instruction_memory1 = 32'h0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
        idle();
        memRead_memory1     = 1'b1;
        regWrite_memory1    = 1'b1;
        opcode_memory1      = 7'b0000011;
        rd_memory1          = rd;
        ALU_result_memory1  = addr;
        instruction_memory1 = {17'h0, f3, 12'h003};
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        idle();
        memWrite_memory1    = 1'b1;
        opcode_memory1      = 7'b0100011;
        ALU_result_memory1  = addr;
        store_data_memory1  = data;
        instruction_memory1 = {17'h0, f3, 12'h023};
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        idle();
        reset         = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        step();
        step();
        reset = 1'b0;
        check("rst_load_valid", {31'h0, load_valid_memory2}, 32'h0);
        check("rst_load_data", load_data_memory2, 32'h0);
        check("rst_load_rd", {27'h0, load_rd_memory2}, 32'h0);
        check("rst_prot_err", {31'h0, protocol_error}, 32'h0);
        check("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);

        // Stores: SB, SH, SW lane alignment
        set_store(3'b000, 32'h0000_1003, 32'h0000_00AB);
        #1;
        check("sb_valid", {31'h0, mem_req_valid}, 32'h1);
        check("sb_write", {31'h0, mem_req_write}, 32'h1);
        check("sb_addr", {12'h0, mem_req_address}, 32'h400);
        check("sb_data", mem_req_data, 32'hABAB_ABAB);
        check("sb_be", {28'h0, mem_req_byte_en}, 32'h8);
        check("sb_stall", {31'h0, stall_memory1}, 32'h0);
        step();
        set_store(3'b001, 32'h0000_1003, 32'hFFFF_1234);
        #1;
        check("sh_data", mem_req_data, 32'h1234_1234);
        check("sh_be", {28'h0, mem_req_byte_en}, 32'hC);
        step();
        set_store(3'b010, 32'h0000_1001, 32'hDEAD_BEEF);
        #1;
        check("sw_data", mem_req_data, 32'hDEAD_BEEF);
        check("sw_be", {28'h0, mem_req_byte_en}, 32'hF);
        step();

        // LH then LHU returning 0x80011234 from 0x2002
        set_load(5'd7, 3'b001, 32'h0000_2002);
        #1;
        check("lh_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("lh_req_write", {31'h0, mem_req_write}, 32'h0);
        check("lh_addr", {12'h0, mem_req_address}, 32'h800);
        check("lh_be", {28'h0, mem_req_byte_en}, 32'hF);
        step();
        idle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h8001_1234;
        #1;
        check("lh_not_early", {31'h0, load_valid_memory2}, 32'h0);
        step();
        mem_rsp_valid = 1'b0;
        check("lh_valid", {31'h0, load_valid_memory2}, 32'h1);
        check("lh_rd", {27'h0, load_rd_memory2}, 32'd7);
        check("lh_data", load_data_memory2, 32'hFFFF_8001);
        step();
        check("lh_valid_one_cycle", {31'h0, load_valid_memory2}, 32'h0);
        set_load(5'd8, 3'b101, 32'h0000_2002);
        step();
        idle();
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        check("lhu_rd", {27'h0, load_rd_memory2}, 32'd8);
        check("lhu_data", load_data_memory2, 32'h0000_8001);

        // Load held off by ready=0 for three cycles
        set_load(5'd9, 3'b010, 32'h0000_0010);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nrdy_stall", {31'h0, stall_memory1}, 32'h1);
            check("nrdy_valid", {31'h0, mem_req_valid}, 32'h1);
            check("nrdy_addr", {12'h0, mem_req_address}, 32'h4);
            step();
        end
        mem_req_ready = 1'b1;
        #1;
        check("rdy_stall", {31'h0, stall_memory1}, 32'h0);
        step();
        idle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1122_3344;
        step();
        mem_rsp_valid = 1'b0;
        check("lw_rd", {27'h0, load_rd_memory2}, 32'd9);
        check("lw_data", load_data_memory2, 32'h1122_3344);

        // Fill the tracker, stall the third load, then push+pop together
        set_load(5'd3, 3'b000, 32'h0000_2003);
        step();
        set_load(5'd4, 3'b100, 32'h0000_2001);
        step();
        set_load(5'd5, 3'b010, 32'h0000_3000);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h8001_1234;
        #1;
        check("full_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("full_stall", {31'h0, stall_memory1}, 32'h1);
        step();
        check("ord1_rd", {27'h0, load_rd_memory2}, 32'd3);
        check("ord1_lb_data", load_data_memory2, 32'hFFFF_FF80);
        check("slot_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("slot_stall", {31'h0, stall_memory1}, 32'h0);
        step();
        idle();
        check("ord2_rd", {27'h0, load_rd_memory2}, 32'd4);
        check("ord2_lbu_data", load_data_memory2, 32'h0000_0012);
        mem_rsp_data = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        check("ord3_rd", {27'h0, load_rd_memory2}, 32'd5);
        check("ord3_data", load_data_memory2, 32'hCAFE_F00D);
        check("no_err_yet", {31'h0, protocol_error}, 32'h0);

        // Response with empty tracker
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_AAAA;
        step();
        mem_rsp_valid = 1'b0;
        check("empty_no_valid", {31'h0, load_valid_memory2}, 32'h0);
        check("empty_prot_err", {31'h0, protocol_error}, 32'h1);
        step();
        check("prot_err_sticky", {31'h0, protocol_error}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("prot_err_cleared", {31'h0, protocol_error}, 32'h0);
        idle();
        memRead_memory1 = 1'b1;
        #1;
        check("op0_no_req", {31'h0, mem_req_valid}, 32'h0);
        check("op0_no_stall", {31'h0, stall_memory1}, 32'h0);
        step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
